// File: rtl/mux_recirc_pkg.sv
// Shared types and limits for the multi-channel mux-recirculation receive synchronizer.
// Optional parity checking is enabled by defining MUX_RECIRC_PARITY_EN.
package mux_recirc_pkg;

  localparam int MIN_SYNC_STAGES = 2;

  // Per-channel handshake bookkeeping kept alongside the captured word
  typedef struct packed {
    logic pending;
    logic overrun;
  } ch_state_t;

endpackage

// File: rtl/mux_recirc_sync_rx_mc_if.sv
// Bus bundle between an asynchronous multi-channel source and the receive synchronizer.
// Defining MUX_RECIRC_PARITY_EN adds the req_par / par_err signals.
interface mux_recirc_sync_rx_mc_if #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4
);
  logic [NCH*WIDTH-1:0] A;
  logic [NCH-1:0]       req_tgl;
  logic                 hold;
  logic                 ovr_clr;
  logic [NCH*WIDTH-1:0] B;
  logic [NCH-1:0]       upd;
  logic [NCH-1:0]       ack_tgl;
  logic [NCH-1:0]       overrun;
`ifdef MUX_RECIRC_PARITY_EN
  logic [NCH-1:0]       req_par;
  logic [NCH-1:0]       par_err;

  modport master (output A, req_tgl, hold, ovr_clr, req_par,
                  input  B, upd, ack_tgl, overrun, par_err);
  modport slave  (input  A, req_tgl, hold, ovr_clr, req_par,
                  output B, upd, ack_tgl, overrun, par_err);
`else
  modport master (output A, req_tgl, hold, ovr_clr,
                  input  B, upd, ack_tgl, overrun);
  modport slave  (input  A, req_tgl, hold, ovr_clr,
                  output B, upd, ack_tgl, overrun);
`endif
endinterface

// File: rtl/mux_recirc_ch.sv
// One receive channel: request-toggle synchronizer, edge detect, pending/overrun and load/recirculate data register.
// Defining MUX_RECIRC_PARITY_EN adds the sticky parity-error flag.
module mux_recirc_ch
  import mux_recirc_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic             req,
  input  logic             hold,
  input  logic             ovr_clr,
`ifdef MUX_RECIRC_PARITY_EN
  input  logic             req_par,
  output logic             par_err,
`endif
  output logic [WIDTH-1:0] b,
  output logic             upd,
  output logic             ack,
  output logic             overrun
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   sync_d;
  ch_state_t              state;
  logic                   evt;
  logic                   cap;

  assign evt     = sync[SYNC_STAGES-1] ^ sync_d;
  assign cap     = (evt | state.pending) & ~hold;
  assign overrun = state.overrun;

  // A request seen while another is still pending is folded into one capture of the latest word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync   <= '0;
      sync_d <= 1'b0;
      state  <= '0;
      b      <= '0;
      upd    <= 1'b0;
      ack    <= 1'b0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], req};
      sync_d <= sync[SYNC_STAGES-1];
      if (cap) begin
        b             <= a;
        ack           <= ~ack;
        upd           <= 1'b1;
        state.pending <= 1'b0;
      end else begin
        upd <= 1'b0;
        if (evt) state.pending <= 1'b1;
      end
      if (ovr_clr)
        state.overrun <= 1'b0;
      else if (evt && hold && state.pending)
        state.overrun <= 1'b1;
    end
  end

`ifdef MUX_RECIRC_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      par_err <= 1'b0;
    else if (ovr_clr)
      par_err <= 1'b0;
    else if (cap)
      par_err <= par_err | (^a ^ req_par);
  end
`endif

endmodule

// File: rtl/mux_recirc_sync_rx_mc.sv
// Multi-channel mux-recirculation CDC receiver: NCH independent channels, bus packing only at this level.
// Defining MUX_RECIRC_PARITY_EN enables per-channel even-parity checking.
module mux_recirc_sync_rx_mc
  import mux_recirc_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int NCH         = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    c2,
  input  logic                    rstn,
  mux_recirc_sync_rx_mc_if.slave  bus
);

  if (WIDTH < 1) begin : g_bad_width
    $error("mux_recirc_sync_rx_mc: WIDTH must be >= 1");
  end
  if (NCH < 1) begin : g_bad_nch
    $error("mux_recirc_sync_rx_mc: NCH must be >= 1");
  end
  if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_sync
    $error("mux_recirc_sync_rx_mc: SYNC_STAGES below minimum");
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    mux_recirc_ch #(
      .WIDTH      (WIDTH),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_ch (
      .clk     (c2),
      .rst_n   (rstn),
      .a       (bus.A[i*WIDTH +: WIDTH]),
      .req     (bus.req_tgl[i]),
      .hold    (bus.hold),
      .ovr_clr (bus.ovr_clr),
`ifdef MUX_RECIRC_PARITY_EN
      .req_par (bus.req_par[i]),
      .par_err (bus.par_err[i]),
`endif
      .b       (bus.B[i*WIDTH +: WIDTH]),
      .upd     (bus.upd[i]),
      .ack     (bus.ack_tgl[i]),
      .overrun (bus.overrun[i])
    );
  end

endmodule

// File: tb/tb_mux_recirc_sync_rx_mc.sv
// Scoreboard bench for mux_recirc_sync_rx_mc; source runs on an async 10ns clock, c2 is 14ns.
// Define MUX_RECIRC_PARITY_EN to also exercise the parity checks.
`timescale 1ns/100ps
module tb_mux_recirc_sync_rx_mc;
  localparam int WIDTH       = 8;
  localparam int NCH         = 4;
  localparam int SYNC_STAGES = 2;

  logic c2;
  logic sclk;
  logic rstn;

  mux_recirc_sync_rx_mc_if #(.WIDTH(WIDTH), .NCH(NCH)) bus ();

  mux_recirc_sync_rx_mc #(
    .WIDTH      (WIDTH),
    .NCH        (NCH),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .c2  (c2),
    .rstn(rstn),
    .bus (bus)
  );

  logic [WIDTH-1:0] srcData [NCH];
  logic [NCH-1:0]   srcReq;
  logic [NCH-1:0]   srcParBad;
  logic [WIDTH-1:0] expQ [NCH][$];
  int               updCount [NCH];
  int               checks   = 0;
  int               failures = 0;

  // c2 edges sit on fractional times so they never coincide with source edges
  initial begin
    c2 = 1'b0;
    #0.3;
    forever #7 c2 = ~c2;
  end

  initial begin
    sclk = 1'b0;
    forever #5 sclk = ~sclk;
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) bus.A[i*WIDTH +: WIDTH] = srcData[i];
    bus.req_tgl = srcReq;
`ifdef MUX_RECIRC_PARITY_EN
    for (int i = 0; i < NCH; i++) bus.req_par[i] = (^srcData[i]) ^ srcParBad[i];
`endif
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // Every upd pulse must match the oldest outstanding word for that channel
  always @(negedge c2) begin
    if (rstn) begin
      for (int i = 0; i < NCH; i++) begin
        if (bus.upd[i]) begin
          updCount[i]++;
          if (expQ[i].size() == 0)
            checkOutput($sformatf("upd_spurious_ch%0d", i), 32'd1, 32'd0);
          else
            checkOutput($sformatf("data_ch%0d", i), 32'(bus.B[i*WIDTH +: WIDTH]), 32'(expQ[i].pop_front()));
        end
      end
    end
  end

  task automatic applyStimulus(input int ch, input logic [WIDTH-1:0] data, input bit push, input bit waitAck);
    logic prevAck;
    bit   seen;
    @(posedge sclk);
    srcData[ch] = data;
    @(posedge sclk);
    prevAck = bus.ack_tgl[ch];
    srcReq[ch] = ~srcReq[ch];
    if (push) expQ[ch].push_back(data);
    if (waitAck) begin
      seen = 1'b0;
      for (int n = 0; n < 100 && !seen; n++) begin
        @(posedge sclk);
        if (bus.ack_tgl[ch] != prevAck) seen = 1'b1;
      end
      if (!seen) checkOutput($sformatf("ack_timeout_ch%0d", ch), 32'd0, 32'd1);
    end
  endtask

  task automatic soakChannel(input int ch);
    for (int n = 0; n < 15; n++) begin
      applyStimulus(ch, WIDTH'($urandom), 1'b1, 1'b1);
      repeat ($urandom_range(0, 3)) @(posedge sclk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout actual=running required=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int cnt;
    int base;
    bit seen;

    for (int i = 0; i < NCH; i++) begin
      srcData[i]  = WIDTH'($urandom);
      updCount[i] = 0;
    end
    srcReq      = NCH'($urandom);
    srcParBad   = '0;
    bus.hold    = 1'b0;
    bus.ovr_clr = 1'b0;
    rstn        = 1'b0;

    // Reset with random inputs
    #50;
    checkOutput("reset_B", bus.B, 32'd0);
    checkOutput("reset_upd", 32'(bus.upd), 32'd0);
    checkOutput("reset_ack", 32'(bus.ack_tgl), 32'd0);
    checkOutput("reset_overrun", 32'(bus.overrun), 32'd0);
    srcReq = '0;
    #20;
    @(negedge c2) rstn = 1'b1;

    // Reset mid-transfer drops the word silently
    @(posedge sclk);
    srcReq[0] = 1'b1;
    @(posedge c2);
    @(negedge c2);
    rstn   = 1'b0;
    srcReq = '0;
    #30;
    @(negedge c2) rstn = 1'b1;
    repeat (10) @(negedge c2);
    checkOutput("midreset_upd_count", 32'(updCount[0] + updCount[1] + updCount[2] + updCount[3]), 32'd0);
    checkOutput("midreset_B", bus.B, 32'd0);
    checkOutput("midreset_ack", 32'(bus.ack_tgl), 32'd0);

    // Single transfer with latency measurement
    @(posedge sclk);
    srcData[0] = 8'hA5;
    @(posedge sclk);
    srcReq[0] = 1'b1;
    expQ[0].push_back(8'hA5);
    cnt  = 0;
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(posedge c2);
      cnt++;
      @(negedge c2);
      if (bus.upd[0]) seen = 1'b1;
    end
    checkOutput("single_latency", 32'(cnt), 32'(SYNC_STAGES + 1));
    @(negedge c2);
    checkOutput("single_upd_one_cycle", 32'(bus.upd[0]), 32'd0);
    checkOutput("single_ack", 32'(bus.ack_tgl), 32'h1);
    checkOutput("single_others_B", 32'(bus.B[31:8]), 32'd0);

    // Recirculation: data changes without a toggle
    @(posedge sclk);
    srcData[0] = 8'h3C;
    repeat (20) @(negedge c2);
    checkOutput("recirc_B0", 32'(bus.B[7:0]), 32'hA5);
    checkOutput("recirc_upd_count", 32'(updCount[0]), 32'd1);

    // Hold defers captures; release captures all pending together
    @(negedge c2) bus.hold = 1'b1;
    applyStimulus(1, 8'h11, 1'b1, 1'b0);
    applyStimulus(2, 8'h22, 1'b1, 1'b0);
    repeat (8) @(negedge c2);
    checkOutput("hold_no_upd", 32'(updCount[1] + updCount[2]), 32'd0);
    bus.hold = 1'b0;
    @(negedge c2);
    checkOutput("hold_release_upd", 32'(bus.upd[2:1]), 32'h3);
    repeat (4) @(negedge c2);
    checkOutput("hold_upd_once", 32'(updCount[1] + updCount[2]), 32'd2);
    checkOutput("hold_ack", 32'(bus.ack_tgl), 32'h7);

    // Overrun: two requests while held, only the latest word is captured
    base = updCount[3];
    @(negedge c2) bus.hold = 1'b1;
    applyStimulus(3, 8'h01, 1'b0, 1'b0);
    repeat (6) @(negedge c2);
    applyStimulus(3, 8'h02, 1'b1, 1'b0);
    repeat (6) @(negedge c2);
    checkOutput("overrun_set", 32'(bus.overrun), 32'h8);
    checkOutput("overrun_no_upd", 32'(updCount[3] - base), 32'd0);
    bus.hold = 1'b0;
    @(negedge c2);
    checkOutput("overrun_release_upd", 32'(bus.upd[3]), 32'd1);
    repeat (5) @(negedge c2);
    checkOutput("overrun_single_upd", 32'(updCount[3] - base), 32'd1);
    checkOutput("overrun_ack", 32'(bus.ack_tgl[3]), 32'd1);
    bus.ovr_clr = 1'b1;
    @(negedge c2) bus.ovr_clr = 1'b0;
    checkOutput("overrun_clear", 32'(bus.overrun), 32'd0);

`ifdef MUX_RECIRC_PARITY_EN
    // Bad parity is flagged but the data is still captured
    srcParBad[0] = 1'b1;
    applyStimulus(0, 8'h07, 1'b1, 1'b1);
    repeat (2) @(negedge c2);
    checkOutput("parity_err_ch0", 32'(bus.par_err[0]), 32'd1);
    checkOutput("parity_B0", 32'(bus.B[7:0]), 32'h07);
    srcParBad[0] = 1'b0;
    applyStimulus(1, 8'h5A, 1'b1, 1'b1);
    applyStimulus(2, 8'hC3, 1'b1, 1'b1);
    applyStimulus(3, 8'h80, 1'b1, 1'b1);
    repeat (2) @(negedge c2);
    checkOutput("parity_ok_others", 32'(bus.par_err[3:1]), 32'd0);
`endif

    // Random soak on all channels at once
    fork
      soakChannel(0);
      soakChannel(1);
      soakChannel(2);
      soakChannel(3);
    join
    repeat (10) @(negedge c2);
    for (int i = 0; i < NCH; i++)
      checkOutput($sformatf("soak_drain_ch%0d", i), 32'(expQ[i].size()), 32'd0);
    checkOutput("soak_overrun", 32'(bus.overrun), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
